// File: rtl/core_loader.sv
// Clears every MARS core cell to a fill instruction, then streams warrior images into core.
// Latency: one clear write per cycle; load beats are written at the edge that accepts them; reports are registered (+1 cycle).
// Backpressure: ready is high throughout LOAD and low elsewhere; beats are accepted only when valid is high.

`ifndef CORESIZE
`define CORESIZE 8000
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 42
`endif

module core_loader #(
    parameter int CORESIZE    = `CORESIZE,
    parameter int ADDR_WIDTH  = $clog2(CORESIZE),
    parameter int INSTR_WIDTH = `INSTR_WIDTH,
    parameter int MAXLENGTH   = 100,
    parameter int MAXWARRIORS = 8,
    localparam int NW_W       = $clog2(MAXWARRIORS + 1),
    localparam int IDX_W      = $clog2(MAXWARRIORS),
    localparam int LEN_W      = $clog2(MAXLENGTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [NW_W-1:0]        i_nwarriors,
    input  logic [INSTR_WIDTH-1:0] i_clear_instr,
    input  logic                   i_ld_valid,
    output logic                   o_ld_ready,
    input  logic [INSTR_WIDTH-1:0] i_ld_data,
    input  logic [ADDR_WIDTH-1:0]  i_ld_base,
    input  logic                   i_ld_last,
    output logic [ADDR_WIDTH-1:0]  o_core_pc,
    output logic [ADDR_WIDTH-1:0]  o_core_woffs,
    output logic [INSTR_WIDTH-1:0] o_core_din,
    output logic [5:0]             o_core_we,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_err,
    output logic                   o_wload_valid,
    output logic [IDX_W-1:0]       o_wload_idx,
    output logic [ADDR_WIDTH-1:0]  o_wload_base,
    output logic [LEN_W-1:0]       o_wload_len
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_LOAD  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;       // clear address counter
    logic [NW_W-1:0]        widx_q, widx_d;       // warrior index within this load
    logic [LEN_W-1:0]       off_q, off_d;         // offset within current warrior
    logic [ADDR_WIDTH-1:0]  base_q, base_d;       // base held after the first beat
    logic [NW_W-1:0]        nw_q, nw_d;           // latched warrior count
    logic [INSTR_WIDTH-1:0] fill_q, fill_d;       // latched fill instruction
    logic                   done_q, done_d;
    logic                   wl_vld_q, wl_vld_d;
    logic [IDX_W-1:0]       wl_idx_q, wl_idx_d;
    logic [ADDR_WIDTH-1:0]  wl_base_q, wl_base_d;
    logic [LEN_W-1:0]       wl_len_q, wl_len_d;

    logic [ADDR_WIDTH-1:0]  base_eff;
    logic [ADDR_WIDTH:0]    addr_sum;
    logic [ADDR_WIDTH-1:0]  load_pc;
    logic [NW_W-1:0]        widx_inc;

    // Load address: base plus offset folded once into 0..CORESIZE-1.
    always_comb begin
        base_eff = (off_q == '0) ? i_ld_base : base_q;
        addr_sum = {1'b0, base_eff} + (ADDR_WIDTH+1)'(off_q);
        if (addr_sum >= (ADDR_WIDTH+1)'(CORESIZE)) begin
            load_pc = ADDR_WIDTH'(addr_sum - (ADDR_WIDTH+1)'(CORESIZE));
        end else begin
            load_pc = addr_sum[ADDR_WIDTH-1:0];
        end
        widx_inc = widx_q + 1'b1;
    end

    // Next-state and counter updates for the clear/load sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        widx_d    = widx_q;
        off_d     = off_q;
        base_d    = base_q;
        nw_d      = nw_q;
        fill_d    = fill_q;
        done_d    = 1'b0;
        wl_vld_d  = 1'b0;
        wl_idx_d  = wl_idx_q;
        wl_base_d = wl_base_q;
        wl_len_d  = wl_len_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (i_start) begin
                    nw_d    = i_nwarriors;
                    fill_d  = i_clear_instr;
                    addr_d  = '0;
                    widx_d  = '0;
                    off_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == ADDR_WIDTH'(CORESIZE - 1)) begin
                    addr_d = '0;
                    if (nw_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (i_ld_valid) begin
                    if (off_q == '0) begin
                        base_d = i_ld_base;
                    end
                    if (i_ld_last) begin
                        wl_vld_d  = 1'b1;
                        wl_idx_d  = IDX_W'(widx_q);
                        wl_base_d = base_eff;
                        wl_len_d  = off_q + 1'b1;
                        off_d     = '0;
                        widx_d    = widx_inc;
                        if (widx_inc == nw_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else if (off_q == LEN_W'(MAXLENGTH - 1)) begin
                        // Over-long warrior: the beat is written, then the load aborts.
                        state_d = S_ERROR;
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            widx_q    <= '0;
            off_q     <= '0;
            base_q    <= '0;
            nw_q      <= '0;
            fill_q    <= '0;
            done_q    <= 1'b0;
            wl_vld_q  <= 1'b0;
            wl_idx_q  <= '0;
            wl_base_q <= '0;
            wl_len_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            widx_q    <= widx_d;
            off_q     <= off_d;
            base_q    <= base_d;
            nw_q      <= nw_d;
            fill_q    <= fill_d;
            done_q    <= done_d;
            wl_vld_q  <= wl_vld_d;
            wl_idx_q  <= wl_idx_d;
            wl_base_q <= wl_base_d;
            wl_len_q  <= wl_len_d;
        end
    end

    // Core write port: clear writes from the counter, load writes follow the stream directly.
    always_comb begin
        o_core_pc  = '0;
        o_core_din = '0;
        o_core_we  = '0;
        o_ld_ready = 1'b0;
        case (state_q)
            S_CLEAR: begin
                o_core_pc  = addr_q;
                o_core_din = fill_q;
                o_core_we  = 6'b111111;
            end
            S_LOAD: begin
                o_ld_ready = 1'b1;
                o_core_pc  = load_pc;
                o_core_din = i_ld_data;
                o_core_we  = {6{i_ld_valid}};
            end
            default: ;
        endcase
    end

    assign o_core_woffs  = '0;
    assign o_busy        = (state_q == S_CLEAR) || (state_q == S_LOAD);
    assign o_err         = (state_q == S_ERROR);
    assign o_done        = done_q;
    assign o_wload_valid = wl_vld_q;
    assign o_wload_idx   = wl_idx_q;
    assign o_wload_base  = wl_base_q;
    assign o_wload_len   = wl_len_q;

endmodule

// File: tb/tb_core_loader.sv
// Directed bench for core_loader with a 16-cell core, 4-beat warriors and up to 4 warriors.
// Latency: clear starts the cycle after start; load beats land at the accepting edge.
// Backpressure: stream valid is toggled to exercise stalls and the error-state ready drop.

module tb_core_loader;

    localparam int CS = 16;
    localparam int AW = 4;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    nwarriors;
    logic [IW-1:0] clear_instr;
    logic          ld_valid;
    logic          ld_ready;
    logic [IW-1:0] ld_data;
    logic [AW-1:0] ld_base;
    logic          ld_last;
    logic [AW-1:0] core_pc;
    logic [AW-1:0] core_woffs;
    logic [IW-1:0] core_din;
    logic [5:0]    core_we;
    logic          busy;
    logic          done;
    logic          err;
    logic          wload_valid;
    logic [1:0]    wload_idx;
    logic [AW-1:0] wload_base;
    logic [2:0]    wload_len;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int snap;
    logic [IW-1:0] mem [CS];

    core_loader #(
        .CORESIZE(CS), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW),
        .MAXLENGTH(4), .MAXWARRIORS(4)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_nwarriors(nwarriors), .i_clear_instr(clear_instr),
        .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_data(ld_data),
        .i_ld_base(ld_base), .i_ld_last(ld_last),
        .o_core_pc(core_pc), .o_core_woffs(core_woffs), .o_core_din(core_din),
        .o_core_we(core_we), .o_busy(busy), .o_done(done), .o_err(err),
        .o_wload_valid(wload_valid), .o_wload_idx(wload_idx),
        .o_wload_base(wload_base), .o_wload_len(wload_len)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the core memory write port.
    always @(posedge clk) begin
        if (core_we != 6'd0) begin
            mem[core_pc] <= core_din;
            wr_cnt       <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; nwarriors = '0; clear_instr = '0;
        ld_valid = 1'b0; ld_data = '0; ld_base = '0; ld_last = 1'b0;
        repeat (3) cyc();
        #1;
        chk("rst_pc", core_pc, 0);
        chk("rst_woffs", core_woffs, 0);
        chk("rst_din", core_din, 0);
        chk("rst_we", core_we, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_wvld", wload_valid, 0);
        chk("rst_widx", wload_idx, 0);
        chk("rst_wbase", wload_base, 0);
        chk("rst_wlen", wload_len, 0);

        // Start a clear, then reset in the middle of it at k=5.
        rst_n = 1'b1; start = 1'b1; nwarriors = 3'd0; clear_instr = 16'hA5A5;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("midclr_pc", core_pc, k);
            cyc();
        end
        chk("midclr_pc5", core_pc, 5);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_pc", core_pc, 0);
        chk("midrst_we", core_we, 0);
        chk("midrst_din", core_din, 0);
        cyc();
        chk("idle_busy", busy, 0);

        // Full clear with zero warriors.
        start = 1'b1; nwarriors = 3'd0; clear_instr = 16'hA5A5;
        cyc();
        start = 1'b0;
        snap = wr_cnt;
        for (int k = 0; k < CS; k++) begin
            chk("clr_pc", core_pc, k);
            chk("clr_we", core_we, 6'h3F);
            chk("clr_din", core_din, 16'hA5A5);
            chk("clr_done", done, 0);
            cyc();
        end
        chk("clr_done_pulse", done, 1);
        chk("clr_busy_low", busy, 0);
        chk("clr_wr_count", wr_cnt - snap, 16);
        cyc();
        chk("clr_done_end", done, 0);
        for (int i = 0; i < CS; i++) chk("clr_mem", mem[i], 16'hA5A5);

        // Two warriors, with a stall and an ignored start inside LOAD.
        start = 1'b1; nwarriors = 3'd2; clear_instr = 16'h1111;
        cyc();
        start = 1'b0;
        repeat (CS) cyc();
        chk("ld_ready", ld_ready, 1);
        chk("ld_busy", busy, 1);
        chk("ld_we_idle", core_we, 0);
        ld_valid = 1'b1; ld_base = 4'd3; ld_data = 16'hD000; ld_last = 1'b0;
        #1;
        chk("w0b0_pc", core_pc, 3);
        chk("w0b0_we", core_we, 6'h3F);
        chk("w0b0_din", core_din, 16'hD000);
        cyc();
        ld_valid = 1'b0; ld_base = 4'd9; ld_data = 16'hBAD0;
        start = 1'b1; nwarriors = 3'd0;
        #1;
        chk("stall0_we", core_we, 0);
        cyc();
        start = 1'b0;
        #1;
        chk("stall1_we", core_we, 0);
        chk("stall1_busy", busy, 1);
        chk("stall1_err", err, 0);
        cyc();
        ld_valid = 1'b1; ld_data = 16'hD001;
        #1;
        chk("w0b1_pc", core_pc, 4);
        cyc();
        ld_data = 16'hD002; ld_last = 1'b1;
        #1;
        chk("w0b2_pc", core_pc, 5);
        chk("w0b2_wvld", wload_valid, 0);
        cyc();
        ld_base = 4'd14; ld_data = 16'hE000; ld_last = 1'b0;
        #1;
        chk("w0_rep_vld", wload_valid, 1);
        chk("w0_rep_idx", wload_idx, 0);
        chk("w0_rep_base", wload_base, 3);
        chk("w0_rep_len", wload_len, 3);
        chk("w0_rep_done", done, 0);
        chk("w1b0_pc", core_pc, 14);
        cyc();
        ld_base = 4'd0; ld_data = 16'hE001;
        #1;
        chk("w1b1_pc", core_pc, 15);
        chk("w1b1_wvld", wload_valid, 0);
        cyc();
        ld_data = 16'hE002;
        #1;
        chk("w1b2_pc_wrap", core_pc, 0);
        cyc();
        ld_data = 16'hE003; ld_last = 1'b1;
        #1;
        chk("w1b3_pc", core_pc, 1);
        cyc();
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        chk("w1_rep_vld", wload_valid, 1);
        chk("w1_rep_idx", wload_idx, 1);
        chk("w1_rep_base", wload_base, 14);
        chk("w1_rep_len", wload_len, 4);
        chk("w1_rep_done", done, 1);
        chk("w1_busy_low", busy, 0);
        chk("w1_ready_low", ld_ready, 0);
        cyc();
        chk("post_done", done, 0);
        chk("post_wvld", wload_valid, 0);
        chk("mem3", mem[3], 16'hD000);
        chk("mem4", mem[4], 16'hD001);
        chk("mem5", mem[5], 16'hD002);
        chk("mem14", mem[14], 16'hE000);
        chk("mem15", mem[15], 16'hE001);
        chk("mem0", mem[0], 16'hE002);
        chk("mem1", mem[1], 16'hE003);
        chk("mem2", mem[2], 16'h1111);
        chk("mem6", mem[6], 16'h1111);
        chk("mem9", mem[9], 16'h1111);

        // Over-long warrior: four beats without last abort into ERROR.
        start = 1'b1; nwarriors = 3'd1; clear_instr = 16'h2222;
        cyc();
        start = 1'b0;
        repeat (CS) cyc();
        ld_valid = 1'b1; ld_last = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ld_base = (b == 0) ? 4'd8 : 4'd2;
            ld_data = 16'hF000 + 16'(b);
            #1;
            chk("ovl_pc", core_pc, 8 + b);
            cyc();
        end
        ld_data = 16'hF004;
        #1;
        chk("ovl_err", err, 1);
        chk("ovl_ready", ld_ready, 0);
        chk("ovl_busy", busy, 0);
        chk("ovl_we", core_we, 0);
        chk("ovl_wvld", wload_valid, 0);
        chk("ovl_done", done, 0);
        snap = wr_cnt;
        repeat (2) cyc();
        chk("ovl_no_writes", wr_cnt - snap, 0);
        chk("ovl_err_hold", err, 1);
        ld_valid = 1'b0;
        chk("ovl_mem8", mem[8], 16'hF000);
        chk("ovl_mem11", mem[11], 16'hF003);
        chk("ovl_mem12", mem[12], 16'h2222);
        chk("ovl_mem7", mem[7], 16'h2222);

        // Recovery from ERROR with a fresh start.
        start = 1'b1; nwarriors = 3'd0; clear_instr = 16'h3333;
        cyc();
        start = 1'b0;
        chk("rec_busy", busy, 1);
        chk("rec_err", err, 0);
        chk("rec_pc", core_pc, 0);
        repeat (CS) cyc();
        chk("rec_done", done, 1);
        chk("rec_mem8", mem[8], 16'h3333);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
